// File: rtl/rpc_arb_pkg.sv
// rpc_arb_pkg: shared types and constants for the multi-port RPC arbiter.
package rpc_arb_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WDATA} state_e;
  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;
endpackage

// File: rtl/rpc_arb_route_fifo.sv
// rpc_arb_route_fifo: ordered queue of port indices awaiting read data.
module rpc_arb_route_fifo #(
  parameter int Depth = 4,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;
  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
  endfunction
  assign full_o  = cnt_q == CntW'(Depth);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];
  // a push into a full queue is legal only when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
endmodule

// File: rtl/rpc_multiport_arbiter.sv
// rpc_multiport_arbiter: arbitrates N command/data streams onto one RPC controller,
// locking write bursts to their port and routing read data back in issue order.
module rpc_multiport_arbiter
  import rpc_arb_pkg::*;
#(
  parameter int NumPorts       = 2,
  parameter int AddrWidth      = 20,
  parameter int LenWidth       = 6,
  parameter int DataWidth      = 256,
  parameter int MaskWidth      = DataWidth / 8,
  parameter int MaxOutstanding = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          prio_mode_i,
  input  logic [NumPorts-1:0]           cmd_valid_i,
  output logic [NumPorts-1:0]           cmd_ready_o,
  input  logic [NumPorts-1:0]           cmd_write_i,
  input  logic [NumPorts*AddrWidth-1:0] cmd_addr_i,
  input  logic [NumPorts*LenWidth-1:0]  cmd_len_i,
  input  logic [NumPorts-1:0]           wdata_valid_i,
  output logic [NumPorts-1:0]           wdata_ready_o,
  input  logic [NumPorts*DataWidth-1:0] wdata_i,
  input  logic [NumPorts*MaskWidth-1:0] wmask_i,
  output logic [NumPorts-1:0]           rdata_valid_o,
  input  logic [NumPorts-1:0]           rdata_ready_i,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          rdata_last_o,
  output logic                          mst_cmd_valid_o,
  input  logic                          mst_cmd_ready_i,
  output logic                          mst_cmd_write_o,
  output logic [AddrWidth-1:0]          mst_cmd_addr_o,
  output logic [LenWidth-1:0]           mst_cmd_len_o,
  output logic                          mst_wdata_valid_o,
  input  logic                          mst_wdata_ready_i,
  output logic [DataWidth-1:0]          mst_wdata_o,
  output logic [MaskWidth-1:0]          mst_wmask_o,
  input  logic                          mst_rdata_valid_i,
  output logic                          mst_rdata_ready_o,
  input  logic [DataWidth-1:0]          mst_rdata_i,
  input  logic                          mst_rdata_last_i,
  output logic                          busy_o
);
  localparam int IdxW = $clog2(NumPorts);
  state_e               state_q, state_d;
  logic [IdxW-1:0]      gnt_q, rr_q, win, head;
  logic                 write_q, mode_q, found, cmd_hs, w_hs, fifo_full, fifo_empty;
  logic [AddrWidth-1:0] addr_q;
  logic [LenWidth-1:0]  len_q, beat_q;
  logic [NumPorts-1:0]  elig, gnt_oh, head_oh;
  int                   idx;
  assign elig    = cmd_valid_i & (cmd_write_i | {NumPorts{!fifo_full}});
  assign gnt_oh  = NumPorts'(1) << gnt_q;
  assign head_oh = NumPorts'(1) << head;
  assign cmd_hs  = state_q == CMD && mst_cmd_ready_i;
  assign w_hs    = state_q == WDATA && wdata_valid_i[gnt_q] && mst_wdata_ready_i;
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NumPorts; k++) begin
      idx = prio_mode_i == PRIO_FIXED ? k : int'(rr_q) + k;
      idx = idx >= NumPorts ? idx - NumPorts : idx;
      if (!found && elig[idx]) begin
        win   = IdxW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (found ? CMD : IDLE)
            : state_q == CMD  ? (cmd_hs ? (write_q ? WDATA : IDLE) : CMD)
            : (w_hs && beat_q == len_q ? IDLE : WDATA);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      write_q <= 1'b0;
      mode_q  <= PRIO_RR;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        gnt_q   <= win;
        write_q <= cmd_write_i[win];
        addr_q  <= cmd_addr_i[win*AddrWidth +: AddrWidth];
        len_q   <= cmd_len_i[win*LenWidth +: LenWidth];
        mode_q  <= prio_mode_i;
      end
      // the rotation pointer only moves for grants won under round-robin
      if (cmd_hs && mode_q == PRIO_RR) rr_q <= gnt_q == IdxW'(NumPorts - 1) ? '0 : gnt_q + 1'b1;
      if (cmd_hs) beat_q <= '0;
      else if (w_hs) beat_q <= beat_q + 1'b1;
    end
  end
  assign mst_cmd_valid_o   = state_q == CMD;
  assign mst_cmd_write_o   = write_q;
  assign mst_cmd_addr_o    = addr_q;
  assign mst_cmd_len_o     = len_q;
  assign cmd_ready_o       = cmd_hs ? gnt_oh : '0;
  assign mst_wdata_valid_o = state_q == WDATA && wdata_valid_i[gnt_q];
  assign mst_wdata_o       = wdata_i[gnt_q*DataWidth +: DataWidth];
  assign mst_wmask_o       = wmask_i[gnt_q*MaskWidth +: MaskWidth];
  assign wdata_ready_o     = state_q == WDATA && mst_wdata_ready_i ? gnt_oh : '0;
  assign rdata_valid_o     = !fifo_empty && mst_rdata_valid_i ? head_oh : '0;
  assign mst_rdata_ready_o = !fifo_empty && rdata_ready_i[head];
  assign rdata_o           = mst_rdata_i;
  assign rdata_last_o      = mst_rdata_last_i;
  assign busy_o            = state_q != IDLE || !fifo_empty;
  rpc_arb_route_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_hs && !write_q),
    .pop_i   (mst_rdata_valid_i && mst_rdata_ready_o && mst_rdata_last_i),
    .data_i  (gnt_q),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule
